// File: rtl/reg_bank_pkg.sv
// Shared defaults for the register bank and its scoreboard.
// Address 0 is the hardwired zero register: never written, never marked busy.
package reg_bank_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-writer scoreboard: busy bit per register plus a population count; state updates one edge after the request.
// Issue is refused (iss_ready=0) while the target is busy, unless this cycle's writeback retires that same register.
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic                   iss_ready,
  output logic [2**ADDR_W-1:0]   busy,
  output logic [ADDR_W:0]        busy_cnt
);

  logic                 zero_iss;
  logic                 zero_wb;
  logic                 set;
  logic                 clr;
  logic [2**ADDR_W-1:0] busy_n;
  logic [ADDR_W:0]      cnt_n;

  assign zero_iss  = (iss_addr == ADDR_W'(ZERO_REG));
  assign zero_wb   = (wa == ADDR_W'(ZERO_REG));
  assign iss_ready = !busy[iss_addr] || (we && (wa == iss_addr)) || zero_iss;
  assign set       = iss_valid && iss_ready && !zero_iss;
  // Only retiring a register that is actually pending may decrement the count.
  assign clr       = we && !zero_wb && busy[wa];

  always_comb begin
    busy_n = busy;
    if (clr) busy_n[wa] = 1'b0;
    // A newly accepted producer overrides a same-cycle retire of the same register.
    if (set) busy_n[iss_addr] = 1'b1;
  end

  always_comb begin
    cnt_n = busy_cnt;
    case ({set, clr})
      2'b10:   cnt_n = busy_cnt + {{ADDR_W{1'b0}}, 1'b1};
      2'b01:   cnt_n = busy_cnt - {{ADDR_W{1'b0}}, 1'b1};
      default: cnt_n = busy_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_n;
      busy_cnt <= cnt_n;
    end
  end

endmodule

// File: rtl/reg_bank_sb.sv
// Register file with NUM_RD registered read ports, writeback bypass and a busy scoreboard; reads have 1-cycle latency.
// Issue stalls via combinational iss_ready on a pending destination; reads and writes never stall.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        a;
  logic [NUM_RD*DATA_W-1:0] rd_n;
  logic [NUM_RD-1:0]        rd_busy_n;

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wa        (wa),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  assign wr_en = we && (wa != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (wr_en) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd_n      = '0;
    rd_busy_n = '0;
    a         = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = ra[i*ADDR_W +: ADDR_W];
      if (a == ADDR_W'(ZERO_REG)) begin
        rd_n[i*DATA_W +: DATA_W] = '0;
        rd_busy_n[i]             = 1'b0;
      end else if (we && (wa == a)) begin
        // Same-cycle writeback is forwarded and reported as no longer pending.
        rd_n[i*DATA_W +: DATA_W] = wd;
        rd_busy_n[i]             = 1'b0;
      end else begin
        rd_n[i*DATA_W +: DATA_W] = mem[a];
        rd_busy_n[i]             = busy[a];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd      <= '0;
      rd_busy <= '0;
    end else begin
      rd      <= rd_n;
      rd_busy <= rd_busy_n;
    end
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Scoreboard bench for reg_bank_sb: stimulus queues expected outputs tagged with the edge they belong to,
// a negedge monitor pops and compares them.
module tb_reg_bank_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  localparam int W_RD  = 0;
  localparam int W_BZ  = 1;
  localparam int W_CNT = 2;
  localparam int W_RDY = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*AW-1:0] ra = '0;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rd_busy;
  logic             we = 1'b0;
  logic [AW-1:0]    wa = '0;
  logic [DW-1:0]    wd = '0;
  logic             iss_valid = 1'b0;
  logic [AW-1:0]    iss_addr = '0;
  logic             iss_ready;
  logic [AW:0]      busy_cnt;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    string       name;
    int          what;
    int          port;
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  reg_bank_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .ra        (ra),
    .rd        (rd),
    .rd_busy   (rd_busy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // off=0: visible in the current cycle; off=1: visible after the next edge.
  task automatic push(input string name, input int what, input int port, input int off, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.what = what;
    e.port = port;
    e.due  = edge_cnt + off;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int what, input int port);
    case (what)
      W_RD:    return rd[port*DW +: DW];
      W_BZ:    return {31'b0, rd_busy[port]};
      W_CNT:   return 32'(busy_cnt);
      default: return {31'b0, iss_ready};
    endcase
  endfunction

  always @(negedge clk) begin
    int          i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= edge_cnt) begin
        checks++;
        act = actual(sb[i].what, sb[i].port);
        if (sb[i].due < edge_cnt) begin
          errors++;
          $display("FAIL %s: check overdue at edge %0d (due %0d)", sb[i].name, edge_cnt, sb[i].due);
        end else if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", sb[i].name, act, sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we        = 1'b0;
    wa        = '0;
    wd        = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  initial begin
    // Reset state
    cyc();
    push("rst_rd0", W_RD, 0, 0, 32'h0);
    push("rst_rd1", W_RD, 1, 0, 32'h0);
    push("rst_bz0", W_BZ, 0, 0, 32'h0);
    push("rst_cnt", W_CNT, 0, 0, 32'h0);
    push("rst_rdy", W_RDY, 0, 0, 32'h1);
    cyc();
    rst = 1'b0;

    // Write r5 then read it back
    cyc(); idle(); we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; set_ra(5'd0, 5'd0);
    cyc(); idle(); set_ra(5'd5, 5'd0);
    push("wr5_rd0", W_RD, 0, 1, 32'hDEADBEEF);
    push("wr5_rd1", W_RD, 1, 1, 32'h0);
    push("wr5_bz0", W_BZ, 0, 1, 32'h0);

    // Bypass on port 1
    cyc(); idle(); we = 1'b1; wa = 5'd7; wd = 32'h12345678; set_ra(5'd5, 5'd7);
    push("byp_rd1", W_RD, 1, 1, 32'h12345678);
    push("byp_bz1", W_BZ, 1, 1, 32'h0);
    push("byp_rd0", W_RD, 0, 1, 32'hDEADBEEF);

    // Zero register: write, bypass and issue all ignored
    cyc(); idle(); we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; iss_valid = 1'b1; iss_addr = 5'd0; set_ra(5'd0, 5'd0);
    push("r0_rdy", W_RDY, 0, 0, 32'h1);
    push("r0_byp_rd0", W_RD, 0, 1, 32'h0);
    push("r0_cnt", W_CNT, 0, 1, 32'h0);
    cyc(); idle(); set_ra(5'd0, 5'd7);
    push("r0_rd0", W_RD, 0, 1, 32'h0);
    push("r7_rd1", W_RD, 1, 1, 32'h12345678);
    push("r0_cnt2", W_CNT, 0, 1, 32'h0);

    // Issue / reissue / writeback r3
    cyc(); idle(); iss_valid = 1'b1; iss_addr = 5'd3;
    push("iss3_rdy", W_RDY, 0, 0, 32'h1);
    push("iss3_cnt", W_CNT, 0, 1, 32'h1);
    cyc(); idle(); iss_valid = 1'b1; iss_addr = 5'd3; set_ra(5'd3, 5'd0);
    push("reiss3_rdy", W_RDY, 0, 0, 32'h0);
    push("reiss3_cnt", W_CNT, 0, 1, 32'h1);
    push("reiss3_bz0", W_BZ, 0, 1, 32'h1);
    cyc(); idle(); we = 1'b1; wa = 5'd3; wd = 32'h0000A5A5; iss_addr = 5'd3; set_ra(5'd3, 5'd0);
    push("wb3_rdy", W_RDY, 0, 0, 32'h1);
    push("wb3_rd0", W_RD, 0, 1, 32'h0000A5A5);
    push("wb3_bz0", W_BZ, 0, 1, 32'h0);
    push("wb3_cnt", W_CNT, 0, 1, 32'h0);
    cyc(); idle(); iss_addr = 5'd3; set_ra(5'd0, 5'd3);
    push("post3_rdy", W_RDY, 0, 0, 32'h1);
    push("post3_rd1", W_RD, 1, 1, 32'h0000A5A5);
    push("post3_bz1", W_BZ, 1, 1, 32'h0);

    // r9: issue, then issue + writeback together while busy
    cyc(); idle(); iss_valid = 1'b1; iss_addr = 5'd9; set_ra(5'd0, 5'd0);
    push("iss9_rdy", W_RDY, 0, 0, 32'h1);
    push("iss9_cnt", W_CNT, 0, 1, 32'h1);
    cyc(); idle(); iss_valid = 1'b1; iss_addr = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h99990009; set_ra(5'd9, 5'd0);
    push("iswb9_rdy", W_RDY, 0, 0, 32'h1);
    push("iswb9_cnt", W_CNT, 0, 1, 32'h1);
    push("iswb9_rd0", W_RD, 0, 1, 32'h99990009);
    push("iswb9_bz0", W_BZ, 0, 1, 32'h0);
    cyc(); idle(); iss_addr = 5'd9; set_ra(5'd9, 5'd0);
    push("hold9_rdy", W_RDY, 0, 0, 32'h0);
    push("hold9_rd0", W_RD, 0, 1, 32'h99990009);
    push("hold9_bz0", W_BZ, 0, 1, 32'h1);
    push("hold9_cnt", W_CNT, 0, 1, 32'h1);

    // Writeback to idle r12 plus stalled issue to busy r9: count unchanged
    cyc(); idle(); we = 1'b1; wa = 5'd12; wd = 32'h0000000C; iss_valid = 1'b1; iss_addr = 5'd9; set_ra(5'd0, 5'd12);
    push("stall9_rdy", W_RDY, 0, 0, 32'h0);
    push("wb12_cnt", W_CNT, 0, 1, 32'h1);
    push("wb12_rd1", W_RD, 1, 1, 32'h0000000C);
    push("wb12_bz1", W_BZ, 1, 1, 32'h0);

    // Build busy_cnt=4, then reset between edges
    cyc(); idle(); iss_valid = 1'b1; iss_addr = 5'd1; set_ra(5'd0, 5'd0);
    cyc(); idle(); iss_valid = 1'b1; iss_addr = 5'd2;
    cyc(); idle(); iss_valid = 1'b1; iss_addr = 5'd4; set_ra(5'd5, 5'd9);
    cyc(); idle(); set_ra(5'd5, 5'd9);
    push("pre_cnt4", W_CNT, 0, 1, 32'h4);
    push("pre_rd0", W_RD, 0, 1, 32'hDEADBEEF);
    push("pre_rd1", W_RD, 1, 1, 32'h99990009);
    push("pre_bz1", W_BZ, 1, 1, 32'h1);
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    we = 1'b1; wa = 5'd6; wd = 32'h00000066; iss_valid = 1'b1; iss_addr = 5'd10;
    push("arst_rd0", W_RD, 0, 0, 32'h0);
    push("arst_rd1", W_RD, 1, 0, 32'h0);
    push("arst_bz1", W_BZ, 1, 0, 32'h0);
    push("arst_cnt", W_CNT, 0, 0, 32'h0);
    cyc();
    rst = 1'b0;
    idle(); iss_addr = 5'd9; set_ra(5'd6, 5'd9);
    push("rel_rdy9", W_RDY, 0, 0, 32'h1);
    push("rel_rd0", W_RD, 0, 1, 32'h0);
    push("rel_rd1", W_RD, 1, 1, 32'h0);
    push("rel_bz1", W_BZ, 1, 1, 32'h0);
    push("rel_cnt", W_CNT, 0, 1, 32'h0);
    cyc(); idle();

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("FAIL drain: %0d expected entries never checked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
